// File: rtl/sseg_scan_mux_if.sv
// Bus between the character-ROM sequencer (master) and the seven-segment scan stage (slave).
// Optional SSEG_PWM_EN adds the duty input for anode brightness control.
interface sseg_scan_mux_if;
    // Write path is a bare strobe: wr_en qualifies wr_idx/wr_data for one cycle; the slave has
    // no ready and accepts every strobe, so there is no backpressure to honour.
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [7:0] wr_data;
    logic [3:0] blank_mask;
`ifdef SSEG_PWM_EN
    logic [3:0] duty;
`endif
    logic [7:0] sseg;
    logic [3:0] anode;
    logic       frame_tick;
    logic       dbg_show;
    logic [1:0] dbg_digit;

`ifdef SSEG_PWM_EN
    modport master (
        output wr_en, wr_idx, wr_data, blank_mask, duty,
        input  sseg, anode, frame_tick, dbg_show, dbg_digit
    );
    modport slave (
        input  wr_en, wr_idx, wr_data, blank_mask, duty,
        output sseg, anode, frame_tick, dbg_show, dbg_digit
    );
`else
    modport master (
        output wr_en, wr_idx, wr_data, blank_mask,
        input  sseg, anode, frame_tick, dbg_show, dbg_digit
    );
    modport slave (
        input  wr_en, wr_idx, wr_data, blank_mask,
        output sseg, anode, frame_tick, dbg_show, dbg_digit
    );
`endif
endinterface

// File: rtl/sseg_scan_mux.sv
// Double-buffered 4-digit seven-segment scanner with dead time between digit slots.
// Define SSEG_PWM_EN to gate the lit anode with a 4-bit duty cycle.
module sseg_scan_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYC    = 16
) (
    input  logic               clk,
    input  logic               rst,
    sseg_scan_mux_if.slave     bus
);
    localparam int             CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]  SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  DEAD_LAST = CW'(DEAD_CYC - 1);

    typedef enum logic {ST_DEAD, ST_SHOW} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   div_cnt_q, div_cnt_d;
    logic [1:0]      digit_q, digit_d;
    logic [3:0][7:0] pending_q, pending_d;
    logic [3:0][7:0] active_q, active_d;
    logic            dirty_q, dirty_d;
    logic [7:0]      sseg_q, sseg_d;
    logic [3:0]      anode_q, anode_d;
    logic            frame_tick_q, frame_tick_d;
    logic            slot_end;
    logic            commit;
`ifdef SSEG_PWM_EN
    logic [3:0]      pwm_cnt_q, pwm_cnt_d;
`endif

    always_comb begin
        slot_end  = (div_cnt_q == SLOT_LAST);
        commit    = slot_end && (digit_q == 2'd3);
        div_cnt_d = slot_end ? '0 : div_cnt_q + CW'(1);

        state_d = state_q;
        digit_d = digit_q;
        sseg_d  = 8'hFF;
        anode_d = 4'hF;
        case (state_q)
            ST_DEAD: begin
                if (div_cnt_q == DEAD_LAST) state_d = ST_SHOW;
            end
            ST_SHOW: begin
                sseg_d  = active_q[digit_q];
                anode_d = ~(4'b0001 << digit_q) | bus.blank_mask;
`ifdef SSEG_PWM_EN
                if (pwm_cnt_q >= bus.duty) anode_d = 4'hF;
`endif
                if (slot_end) begin
                    state_d = ST_DEAD;
                    digit_d = digit_q + 2'd1;
                end
            end
            default: state_d = ST_DEAD;
        endcase

        // Commit copies the pre-edge pending bank; a same-cycle write lands only in pending
        // and re-arms dirty, so it is picked up at the following frame boundary.
        pending_d = pending_q;
        active_d  = active_q;
        dirty_d   = dirty_q;
        if (commit && dirty_q) begin
            active_d = pending_q;
            dirty_d  = 1'b0;
        end
        if (bus.wr_en) begin
            pending_d[bus.wr_idx] = bus.wr_data;
            dirty_d               = 1'b1;
        end
        frame_tick_d = commit;
`ifdef SSEG_PWM_EN
        pwm_cnt_d = pwm_cnt_q + 4'd1;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_DEAD;
            div_cnt_q    <= '0;
            digit_q      <= 2'd0;
            pending_q    <= '1;
            active_q     <= '1;
            dirty_q      <= 1'b0;
            sseg_q       <= 8'hFF;
            anode_q      <= 4'hF;
            frame_tick_q <= 1'b0;
`ifdef SSEG_PWM_EN
            pwm_cnt_q    <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            digit_q      <= digit_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            dirty_q      <= dirty_d;
            sseg_q       <= sseg_d;
            anode_q      <= anode_d;
            frame_tick_q <= frame_tick_d;
`ifdef SSEG_PWM_EN
            pwm_cnt_q    <= pwm_cnt_d;
`endif
        end
    end

    assign bus.sseg       = sseg_q;
    assign bus.anode      = anode_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.dbg_show   = (state_q == ST_SHOW);
    assign bus.dbg_digit  = digit_q;
endmodule
